cordic_sincos_full: RTL and testbench

//  Iterative CORDIC sine/cosine engine covering the full circle [-pi, pi), successor to the single-output
//  +/-pi/2 trig wrappers. One start yields both sin and cos, via input quadrant folding and output sign fix-up.

---
 rtl/cordic_sincos_full.sv | 190 +++++++++++++++++++
 tb/tb_cordic_sincos_full.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/cordic_sincos_full.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cordic_sincos_full: iterative rotation-mode CORDIC, sin/cos over [-pi, pi) |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module cordic_sincos_full #(
  parameter int BIT_WIDTH  = 16,
  parameter int ITERATIONS = 14,
  parameter int GUARD_BITS = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [BIT_WIDTH-1:0] angle,
  output logic [BIT_WIDTH-1:0] sin_out,
  output logic [BIT_WIDTH-1:0] cos_out,
  output logic                 ready,
  output logic                 done
);

  // x/y are Q2.(BIT_WIDTH-2+GUARD_BITS) with one headroom bit; z shares the width
  localparam int c_iw = BIT_WIDTH + GUARD_BITS + 1;
  localparam int c_cw = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

  // atan(1/q) in Q60 by alternating series; q >= 2 keeps convergence quick
  function automatic longint atan_inv_q60(input longint q);
    longint one, p, acc, term;
    logic   live;
    one  = 64'sd1 <<< 60;
    p    = q;
    acc  = 0;
    live = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (live) begin
        term = (one / p) / longint'(2 * k + 1);
        acc  = (k % 2 == 0) ? acc + term : acc - term;
        if (p > one / (q * q)) live = 1'b0;
        else                   p    = p * q * q;
      end
    end
    return acc;
  endfunction

  function automatic longint pi_q60();
    return 4 * (4 * atan_inv_q60(5) - atan_inv_q60(239));
  endfunction

  // atan(2^-i) expressed in z units (LSB = pi / 2^(BIT_WIDTH-1+GUARD_BITS))
  function automatic longint atan_units(input int i);
    longint a, d;
    int     n;
    n = BIT_WIDTH - 1 + GUARD_BITS;
    if (i == 0) return longint'(1) <<< (n - 2);
    a = atan_inv_q60(longint'(1) <<< i);
    d = pi_q60() >>> (n - 2);
    return ((a <<< 2) + d / 2) / d;
  endfunction

  // K = sqrt(prod 1/(1+2^-2i)), evaluated as K^2 in Q60 then integer sqrt to Q30
  function automatic longint k_fixed();
    longint k2, s, t;
    int     f;
    k2 = 64'sd1 <<< 60;
    for (int i = 0; i < ITERATIONS; i++)
      k2 = k2 - k2 / ((longint'(1) <<< (2 * i)) + 1);
    s = 0;
    for (int b = 30; b >= 0; b--) begin
      t = s | (longint'(1) <<< b);
      if (t * t <= k2) s = t;
    end
    f = BIT_WIDTH - 2 + GUARD_BITS;
    if (f >= 30) return s <<< (f - 30);
    return (s + (longint'(1) <<< (29 - f))) >>> (30 - f);
  endfunction

  localparam logic signed [c_iw-1:0] c_k    = c_iw'(k_fixed());
  localparam logic signed [c_iw-1:0] c_half = c_iw'((1 << GUARD_BITS) >> 1);
  localparam logic signed [c_iw-1:0] c_sat  = c_iw'(1 << (BIT_WIDTH - 2));

  // Round half-up, undo the fold, clamp to +/-1.0
  function automatic logic [BIT_WIDTH-1:0] fix_up(input logic signed [c_iw-1:0] v,
                                                  input logic neg);
    logic signed [c_iw-1:0] r;
    r = (v + c_half) >>> GUARD_BITS;
    if (neg) r = -r;
    if (r > c_sat)       r = c_sat;
    else if (r < -c_sat) r = -c_sat;
    return r[BIT_WIDTH-1:0];
  endfunction

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ROTATE = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;
  logic   w_accept, w_finish;

  logic signed [c_iw-1:0] r_x, r_y, r_z;
  logic        [c_cw-1:0] r_iter;
  logic                   r_neg, r_ready, r_done;
  logic [BIT_WIDTH-1:0]   r_sin, r_cos;

  logic signed [c_iw-1:0] w_atan_tab [ITERATIONS];
  logic signed [c_iw-1:0] w_atan, w_xs, w_ys, w_z_init;
  logic [BIT_WIDTH-1:0]   w_fold;
  logic                   w_neg, w_dir;

  for (genvar g = 0; g < ITERATIONS; g++) begin : g_atan
    assign w_atan_tab[g] = c_iw'(atan_units(g));
  end

  // |angle| >= pi/2 when the top two bits differ; adding pi just flips the MSB
  assign w_neg    = angle[BIT_WIDTH-1] ^ angle[BIT_WIDTH-2];
  assign w_fold   = {angle[BIT_WIDTH-1] ^ w_neg, angle[BIT_WIDTH-2:0]};
  assign w_z_init = c_iw'($signed(w_fold)) <<< GUARD_BITS;

  assign w_dir  = ~r_z[c_iw-1];
  assign w_atan = w_atan_tab[r_iter];
  assign w_xs   = r_x >>> r_iter;
  assign w_ys   = r_y >>> r_iter;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && r_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ROTATE;
        end
      end
      S_ROTATE: begin
        if (r_iter == c_cw'(ITERATIONS - 1)) w_state_nxt = S_FINISH;
      end
      S_FINISH: begin
        w_finish    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_iter  <= '0;
      r_neg   <= 1'b0;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_sin   <= '0;
      r_cos   <= '0;
    end else begin
      r_done  <= w_finish;
      r_ready <= (w_state_nxt == S_IDLE);
      if (w_accept) begin
        r_x    <= c_k;
        r_y    <= '0;
        r_z    <= w_z_init;
        r_iter <= '0;
        r_neg  <= w_neg;
      end else if (r_state == S_ROTATE) begin
        r_x    <= w_dir ? r_x - w_ys   : r_x + w_ys;
        r_y    <= w_dir ? r_y + w_xs   : r_y - w_xs;
        r_z    <= w_dir ? r_z - w_atan : r_z + w_atan;
        r_iter <= r_iter + c_cw'(1);
      end
      if (w_finish) begin
        r_cos <= fix_up(r_x, r_neg);
        r_sin <= fix_up(r_y, r_neg);
      end
    end
  end

  assign sin_out = r_sin;
  assign cos_out = r_cos;
  assign ready   = r_ready;
  assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_cordic_sincos_full.sv
`default_nettype none
// Scoreboard bench for cordic_sincos_full: expected sin/cos queued on accept,
// compared (within tolerance) on each done pulse.
module tb_cordic_sincos_full;

  localparam int BIT_WIDTH = 16;
  localparam int TOL       = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic [BIT_WIDTH-1:0] angle;
  logic [BIT_WIDTH-1:0] sin_out, cos_out;
  logic                 ready, done;

  cordic_sincos_full #(.BIT_WIDTH(16), .ITERATIONS(14), .GUARD_BITS(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .angle   (angle),
    .sin_out (sin_out),
    .cos_out (cos_out),
    .ready   (ready),
    .done    (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int s;
    int c;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   n_done = 0;
  int   cyc    = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string tag, input longint got, input longint exp, input int tol);
    longint diff;
    n_vec++;
    diff = got - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (tol %0d) at cycle %0d", tag, got, exp, tol, cyc);
    end
  endtask

  function automatic int ref_val(input logic [15:0] a, input bit is_sin);
    real th, v;
    th = $itor($signed(a)) * 3.14159265358979 / 32768.0;
    v  = (is_sin ? $sin(th) : $cos(th)) * 16384.0;
    return $rtoi(v + ((v >= 0.0) ? 0.5 : -0.5));
  endfunction

  // Monitor: inputs only change just after posedge, so negedge sees what the next edge samples
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (reset) begin
      sb.delete();
    end else begin
      if (done) begin
        n_done++;
        chk("done_width", prev_done, 0, 0);
        chk("ready_at_done", ready, 1, 0);
        if (sb.size() == 0) begin
          chk("spurious_done", 1, 0, 0);
        end else begin
          e = sb.pop_front();
          chk("sin", $signed(sin_out), e.s, TOL);
          chk("cos", $signed(cos_out), e.c, TOL);
          chk("latency", cyc - e.cyc, 16, 0);
        end
      end
      if (start && ready) begin
        e.s   = ref_val(angle, 1'b1);
        e.c   = ref_val(angle, 1'b0);
        e.cyc = cyc;
        sb.push_back(e);
      end
    end
    prev_done = done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 50 && !ready; k++) tick();
    chk("ready_timeout", ready, 1, 0);
  endtask

  task automatic wait_done(input int n0);
    for (int k = 0; k < 40 && n_done == n0; k++) tick();
    chk("done_timeout", n_done - n0, 1, 0);
  endtask

  task automatic run_one(input logic [15:0] a);
    int n0;
    wait_ready();
    n0    = n_done;
    start = 1'b1;
    angle = a;
    tick();
    start = 1'b0;
    angle = 16'($urandom);
    wait_done(n0);
  endtask

  initial begin
    int n0;
    reset = 1'b1;
    start = 1'b0;
    angle = '0;
    repeat (3) tick();
    chk("rst_sin", sin_out, 0, 0);
    chk("rst_cos", cos_out, 0, 0);
    chk("rst_done", done, 0, 0);
    chk("rst_ready", ready, 0, 0);
    reset = 1'b0;
    tick();
    chk("ready_after_rst", ready, 1, 0);

    run_one(16'h0000);
    chk("zero_cos_exact", $signed(cos_out), 16384, TOL);
    run_one(16'h4000);
    run_one(16'h8000);
    run_one(16'h6000);
    run_one(16'hA000);
    run_one(16'hC000);
    run_one(16'h3FFF);
    run_one(16'hBFFF);
    for (int k = 0; k < 6; k++) run_one(16'($urandom));

    // Starts while busy must be ignored
    wait_ready();
    n0    = n_done;
    start = 1'b1;
    angle = 16'h2AAA;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    angle = 16'hD555;
    tick();
    start = 1'b0;
    repeat (5) tick();
    start = 1'b1;
    angle = 16'h7000;
    tick();
    start = 1'b0;
    repeat (30) tick();
    chk("busy_single_done", n_done - n0, 1, 0);

    // Start held high: back-to-back results with the angle changing every cycle
    wait_ready();
    n0    = n_done;
    start = 1'b1;
    for (int k = 0; k < 80; k++) begin
      angle = 16'($urandom);
      tick();
    end
    start = 1'b0;
    for (int k = 0; k < 40 && sb.size() != 0; k++) tick();
    chk("stream_results", n_done - n0, 5, 0);

    // Reset during iteration 7 aborts the operation
    run_one(16'h6000);
    start = 1'b1;
    angle = 16'h1234;
    tick();
    start = 1'b0;
    repeat (7) tick();
    n0    = n_done;
    reset = 1'b1;
    tick();
    chk("abort_sin", sin_out, 0, 0);
    chk("abort_cos", cos_out, 0, 0);
    chk("abort_done", done, 0, 0);
    chk("abort_ready", ready, 0, 0);
    reset = 1'b0;
    tick();
    chk("abort_ready_back", ready, 1, 0);
    repeat (20) tick();
    chk("abort_no_done", n_done - n0, 0, 0);
    run_one(16'h2000);

    repeat (5) tick();
    chk("sb_empty", sb.size(), 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
